// File: rtl/sprite_blitter.sv
// Multi-sprite blitter: maps the VGA DrawX/DrawY stream onto an external
// synchronous colour ROM holding NUM_SPRITES sprites back-to-back, and
// returns a 3-cycle pipelined colour plus opacity flag keyed on KEY_COLOR.
// Sprite configuration is double-buffered and only swapped at frame_start.
module sprite_blitter #(
  parameter int SPR_W       = 30,
  parameter int SPR_H       = 30,
  parameter int NUM_SPRITES = 4,
  parameter int DATA_WIDTH  = 24,
  parameter int COORD_W     = 10,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR = DATA_WIDTH'(24'hFFFFFF),
  parameter int ROM_AW      = $clog2(NUM_SPRITES*SPR_W*SPR_H)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic                           pix_valid,
  input  logic                           frame_start,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [COORD_W-1:0]             cfg_x,
  input  logic [COORD_W-1:0]             cfg_y,
  input  logic [$clog2(NUM_SPRITES)-1:0] cfg_id,
  input  logic                           cfg_flip,
  input  logic                           cfg_scale2,
  input  logic                           cfg_enable,
  output logic [ROM_AW-1:0]              rom_addr,
  input  logic [DATA_WIDTH-1:0]          rom_data,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_color,
  output logic                           out_opaque
);

  localparam int ID_W  = $clog2(NUM_SPRITES);
  // Two guard bits so x+width never wraps for sprites hanging off the right/bottom edge.
  localparam int EXT_W = COORD_W + 2;

  // Pending (shadow) and active configuration
  logic               pend_vld;
  logic [COORD_W-1:0] pend_x, pend_y, act_x, act_y;
  logic [ID_W-1:0]    pend_id, act_id;
  logic               pend_flip, pend_scale2, pend_enable;
  logic               act_flip, act_scale2, act_enable;
  logic               cfg_xfer;

  // Pipeline control
  logic vld_p1, hit_p1, vld_p2, hit_p2;

  // Stage-1 combinational geometry
  logic [EXT_W-1:0]  px, py, ax, ay, sw, sh, dx, dy, col, row;
  logic              hit_p0;
  logic [ROM_AW-1:0] addr_p0;
  logic              opaque_p2;

  assign cfg_ready = ~pend_vld;
  assign cfg_xfer  = cfg_valid & ~pend_vld;

  // Config double buffer: latch into pending, promote to active on frame_start
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pend_vld    <= 1'b0;
      pend_x      <= '0;
      pend_y      <= '0;
      pend_id     <= '0;
      pend_flip   <= 1'b0;
      pend_scale2 <= 1'b0;
      pend_enable <= 1'b0;
      act_x       <= '0;
      act_y       <= '0;
      act_id      <= '0;
      act_flip    <= 1'b0;
      act_scale2  <= 1'b0;
      act_enable  <= 1'b0;
    end else if (frame_start) begin
      if (pend_vld) begin
        act_x      <= pend_x;
        act_y      <= pend_y;
        act_id     <= pend_id;
        act_flip   <= pend_flip;
        act_scale2 <= pend_scale2;
        act_enable <= pend_enable;
        pend_vld   <= 1'b0;
      end else if (cfg_xfer) begin
        // Empty buffer and a fresh offer on the swap edge: go straight to active.
        act_x      <= cfg_x;
        act_y      <= cfg_y;
        act_id     <= cfg_id;
        act_flip   <= cfg_flip;
        act_scale2 <= cfg_scale2;
        act_enable <= cfg_enable;
      end
    end else if (cfg_xfer) begin
      pend_vld    <= 1'b1;
      pend_x      <= cfg_x;
      pend_y      <= cfg_y;
      pend_id     <= cfg_id;
      pend_flip   <= cfg_flip;
      pend_scale2 <= cfg_scale2;
      pend_enable <= cfg_enable;
    end
  end

  // Stage 0: hit test and sprite-local column/row to ROM address
  always_comb begin
    px  = EXT_W'(DrawX);
    py  = EXT_W'(DrawY);
    ax  = EXT_W'(act_x);
    ay  = EXT_W'(act_y);
    sw  = EXT_W'(SPR_W) << act_scale2;
    sh  = EXT_W'(SPR_H) << act_scale2;
    dx  = px - ax;
    dy  = py - ay;
    col = dx >> act_scale2;
    row = dy >> act_scale2;
    if (act_flip) col = EXT_W'(SPR_W - 1) - col;
    hit_p0 = act_enable && (32'(act_id) < 32'(NUM_SPRITES)) &&
             (px >= ax) && (px < ax + sw) && (py >= ay) && (py < ay + sh);
    addr_p0 = ROM_AW'(32'(act_id) * 32'(SPR_W * SPR_H) +
                      32'(row) * 32'(SPR_W) + 32'(col));
  end

  // Stage 1 boundary: register ROM address (held on miss) and pixel tags
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      hit_p1   <= 1'b0;
    end else begin
      if (hit_p0) rom_addr <= addr_p0;
      vld_p1 <= pix_valid;
      hit_p1 <= hit_p0;
    end
  end

  // Stage 2 boundary: delay tags to line up with the ROM's registered output
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_p2 <= 1'b0;
      hit_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      hit_p2 <= hit_p1;
    end
  end

  assign opaque_p2 = vld_p2 & hit_p2 & (rom_data != KEY_COLOR);

  // Stage 3 boundary: colour key and output register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid  <= 1'b0;
      out_opaque <= 1'b0;
      out_color  <= '0;
    end else begin
      out_valid  <= vld_p2;
      out_opaque <= opaque_p2;
      out_color  <= opaque_p2 ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a behavioural synchronous ROM.
module tb_sprite_blitter;

  localparam int KEY_ADDR = 2737;  // id3, row1, col7 holds the transparent colour

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        pix_valid, frame_start, cfg_valid, cfg_ready;
  logic [9:0]  cfg_x, cfg_y;
  logic [1:0]  cfg_id;
  logic        cfg_flip, cfg_scale2, cfg_enable;
  logic [11:0] rom_addr;
  logic [23:0] rom_data;
  logic        out_valid, out_opaque;
  logic [23:0] out_color;

  int n_chk  = 0;
  int n_pass = 0;

  sprite_blitter dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_id(cfg_id), .cfg_flip(cfg_flip),
    .cfg_scale2(cfg_scale2), .cfg_enable(cfg_enable),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_color(out_color), .out_opaque(out_opaque)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_word(input logic [11:0] a);
    if (a == 12'(KEY_ADDR)) return 24'hFFFFFF;
    return {12'hC3A, a};
  endfunction

  // Synchronous ROM model: one-edge read latency
  always @(posedge Clk) rom_data <= rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_cfg(input int x, input int y, input int id, input logic fl,
                          input logic s2, input logic en);
    @(negedge Clk);
    cfg_x = 10'(x); cfg_y = 10'(y); cfg_id = 2'(id);
    cfg_flip = fl; cfg_scale2 = s2; cfg_enable = en; cfg_valid = 1'b1;
    @(negedge Clk);
    cfg_valid = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  // Present one pixel, check the ROM address after one edge and the
  // output after exactly three edges.
  task automatic pix(input string tag, input int x, input int y,
                     input logic exp_hit, input int exp_addr);
    logic [23:0] w;
    logic        opq;
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
    @(negedge Clk);
    pix_valid = 1'b0;
    if (exp_hit) chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    @(negedge Clk);
    chk({tag, ".early"}, 32'(out_valid), 32'd0);
    @(negedge Clk);
    w   = rom_word(12'(exp_addr));
    opq = exp_hit && (w != 24'hFFFFFF);
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    chk({tag, ".opq"}, 32'(out_opaque), 32'(opq));
    chk({tag, ".col"}, 32'(out_color), opq ? 32'(w) : 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0; DrawX = '0; DrawY = '0; pix_valid = 1'b0;
    frame_start = 1'b0; cfg_valid = 1'b1; cfg_x = 10'd5; cfg_y = 10'd5;
    cfg_id = 2'd1; cfg_flip = 1'b0; cfg_scale2 = 1'b0; cfg_enable = 1'b1;
    repeat (3) @(negedge Clk);
    cfg_valid = 1'b0;
    Reset_n = 1'b1;
    chk("rst.ready", 32'(cfg_ready), 32'd1);
    chk("rst.addr",  32'(rom_addr),  32'd0);
    chk("rst.vld",   32'(out_valid), 32'd0);
    chk("rst.opq",   32'(out_opaque), 32'd0);
    chk("rst.col",   32'(out_color), 32'd0);

    // Config pending but not active until frame_start
    send_cfg(100, 50, 0, 0, 0, 1);
    chk("pend.ready", 32'(cfg_ready), 32'd0);
    pix("pend.miss", 100, 50, 0, 0);
    frame_pulse();
    chk("act.ready", 32'(cfg_ready), 32'd1);
    pix("act.hit", 100, 50, 1, 0);

    // Sprite index and flip
    send_cfg(0, 0, 2, 0, 0, 1); frame_pulse();
    pix("id2", 5, 3, 1, 1895);
    send_cfg(0, 0, 2, 1, 0, 1); frame_pulse();
    pix("flip", 5, 3, 1, 1914);

    // 2x scale
    send_cfg(10, 10, 1, 0, 1, 1); frame_pulse();
    pix("s2.corner", 69, 69, 1, 900 + 29*30 + 29);
    pix("s2.miss",   70, 10, 0, 0);
    pix("s2.origin", 11, 11, 1, 900);

    // Handshake: A accepted, B held until A becomes active
    send_cfg(200, 0, 3, 0, 0, 1);
    chk("hs.readyA", 32'(cfg_ready), 32'd0);
    cfg_x = 10'd300; cfg_valid = 1'b1;
    repeat (3) @(negedge Clk);
    chk("hs.blocked", 32'(cfg_ready), 32'd0);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    chk("hs.rise", 32'(cfg_ready), 32'd1);
    @(negedge Clk);
    chk("hs.takeB", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    pix("hs.A.hit",  200, 0, 1, 2700);
    pix("hs.B.miss", 300, 0, 0, 0);
    frame_pulse();
    pix("hs.B.hit",  300, 0, 1, 2700);
    pix("hs.A.miss", 200, 0, 0, 0);

    // Transparent key colour
    send_cfg(0, 0, 3, 0, 0, 1); frame_pulse();
    pix("key", 7, 1, 1, KEY_ADDR);

    // Right-edge clipping, no wrap
    send_cfg(1010, 0, 0, 0, 0, 1); frame_pulse();
    pix("clip.l",  1010, 0, 1, 0);
    pix("clip.r",  1023, 0, 1, 13);
    pix("clip.w0", 0,    0, 0, 0);
    pix("clip.w15", 15,  0, 0, 0);
    frame_pulse();
    pix("keep", 1023, 0, 1, 13);

    // Transfer coincident with frame_start goes straight to active
    @(negedge Clk);
    cfg_x = 10'd500; cfg_y = 10'd400; cfg_id = 2'd1; cfg_flip = 1'b0;
    cfg_scale2 = 1'b0; cfg_enable = 1'b1; cfg_valid = 1'b1; frame_start = 1'b1;
    @(negedge Clk);
    cfg_valid = 1'b0; frame_start = 1'b0;
    chk("coin.ready", 32'(cfg_ready), 32'd1);
    pix("coin.hit", 500, 400, 1, 900);

    // Reset with three pixels in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      DrawX = 10'(500 + i); DrawY = 10'd400; pix_valid = 1'b1;
    end
    @(negedge Clk);
    pix_valid = 1'b0; Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("mrst.ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("mrst.novld", 32'(out_valid), 32'd0);
      @(negedge Clk);
    end
    pix("mrst.dis", 500, 400, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised successor to the single-sprite 30x30 RGB lookup ROM.
- Takes the VGA controller's DrawX/DrawY stream and a frame-synchronous sprite configuration (position, sprite index, flip, 2x scale, enable).
- Drives an external synchronous multi-sprite colour ROM and returns a pipelined pixel colour with an opacity flag, keyed on a transparent colour.
- The colour mapper uses out_opaque to overlay the sprite on the background.

Parameters:
SPR_W, 30, sprite width in pixels
SPR_H, 30, sprite height in pixels
NUM_SPRITES, 4, sprites stored back-to-back in ROM
DATA_WIDTH, 24, RGB colour width
COORD_W, 10, screen coordinate width
KEY_COLOR, 24'hFFFFFF, transparent colour
ROM_AW, $clog2(NUM_SPRITES*SPR_W*SPR_H), ROM address width (derived)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
DrawX  in  COORD_W  current pixel column
DrawY  in  COORD_W  current pixel row
pix_valid  in  1  DrawX/DrawY valid this cycle
frame_start  in  1  one-cycle pulse at start of vertical blank
cfg_valid  in  1  new config offered
cfg_ready  out  1  config can be accepted
cfg_x  in  COORD_W  sprite left edge
cfg_y  in  COORD_W  sprite top edge
cfg_id  in  $clog2(NUM_SPRITES)  sprite index
cfg_flip  in  1  horizontal mirror
cfg_scale2  in  1  draw at 2x in both axes
cfg_enable  in  1  sprite visible
rom_addr  out  ROM_AW  registered ROM address
rom_data  in  DATA_WIDTH  ROM output; reflects the rom_addr sampled one edge earlier
out_valid  out  1  output pixel valid
out_color  out  DATA_WIDTH  sprite colour; 0 when not opaque
out_opaque  out  1  sprite covers this pixel

Behaviour:
- All state updates on the rising edge of Clk. When Reset_n=0 at an edge:
  - pending and active config cleared (enable=0, x=y=id=flip=scale2=0).
  - All pipeline valids=0.
  - rom_addr=0, out_valid=0, out_color=0, out_opaque=0.
  - cfg_valid is ignored.
  - Reset mid-frame drops in-flight pixels with no partial outputs.
- Config handshake:
  - cfg_ready = ~pending (combinational); it is 1 after reset.
  - Transfer occurs when cfg_valid & cfg_ready; the config is latched into the pending register.
  - At frame_start, pending is copied to active and pending is cleared.
  - If transfer and frame_start coincide (pending was empty), the new config goes straight to active at that edge.
  - frame_start with nothing pending leaves active unchanged.
  - Active config never changes except at frame_start, so there is no tearing.
- Stage 1 (edge after pix_valid):
  - Compute sw = SPR_W<<scale2 and sh = SPR_H<<scale2, using COORD_W+2 bits with no wrap.
  - hit = enable & id<NUM_SPRITES & DrawX>=x & DrawX<x+sw & DrawY>=y & DrawY<y+sh.
  - col = (DrawX-x)>>scale2 and row = (DrawY-y)>>scale2.
  - If flip, col = SPR_W-1-col.
  - rom_addr <= hit ? id*SPR_W*SPR_H + row*SPR_W + col : rom_addr (held).
  - s1_valid <= pix_valid and s1_hit <= hit.
- Stage 2: s2_valid <= s1_valid and s2_hit <= s1_hit, aligned with rom_data.
- Stage 3:
  - out_valid <= s2_valid.
  - out_opaque <= s2_valid & s2_hit & (rom_data != KEY_COLOR).
  - out_color <= out_opaque_next ? rom_data : 0.
- Latency: pixel presented in cycle T produces outputs in cycle T+3. Throughput is one pixel per clock; no stalls; pix_valid gaps propagate as out_valid gaps.
- Sprites partly off-screen (x+sw > 2^COORD_W) are clipped naturally; there is no wrap to column 0.
- An out-of-range cfg_id is accepted, but the sprite never hits.

Test Plan:
- Reset then cfg x=100,y=50,id=0,enable=1, no frame_start; scan (100,50) -> out_opaque=0. After a frame_start pulse, rescan (100,50) -> rom_addr=0, out_color=ROM[0] exactly 3 cycles later, out_opaque=(ROM[0]!=FFFFFF).
- id=2, x=0,y=0: pixel (5,3) -> rom_addr=1800+95=1895. With flip=1 -> rom_addr=1800+90+24=1914.
- scale2=1, x=10,y=10: (69,69) hits with rom_addr=id*900+29*30+29; (70,10) misses; (11,11) -> rom_addr=id*900.
- Handshake: accept cfg A; cfg_ready drops; cfg B held on cfg_valid is not taken until frame_start; A becomes active, ready rises, B is accepted the next cycle, and B becomes active only at the following frame_start.
- ROM word = FFFFFF at a hit pixel -> out_valid=1, out_opaque=0, out_color=0. x=1010 -> DrawX 1010..1023 hit; DrawX 0..15 miss.
- Reset_n low for one edge while 3 pixels are in flight -> no out_valid for those pixels, cfg_ready=1, active enable=0.
